// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the architectural register file and its query ports.
package reg_file_pkg;
  localparam int REG_NUM      = 32;
  localparam int REG_IDX_W    = 5;
  localparam int DATA_W       = 32;
  localparam int ROB_SIZE_BIT = 4;
  localparam int ROB_SIZE     = 1 << ROB_SIZE_BIT;

  typedef logic [REG_IDX_W-1:0]    reg_idx_t;
  typedef logic [ROB_SIZE_BIT-1:0] rob_tag_t;
  typedef logic [DATA_W-1:0]       word_t;

  typedef struct packed {
    logic     busy;
    rob_tag_t dep;
    word_t    value;
  } qry_rsp_t;
endpackage

// File: rtl/reg_file_if.sv
// Commit/rename update bus from the ROB plus the two Decoder operand query ports.
interface reg_file_if;
  import reg_file_pkg::*;

  logic     rob_clear;
  logic     is_update_val;
  reg_idx_t update_val_id;
  rob_tag_t update_val_dep;
  word_t    update_val;
  logic     is_update_dep;
  reg_idx_t update_dep_id;
  rob_tag_t update_dep;
  reg_idx_t rf_qry1_id, rf_qry2_id;
  logic     rf_qry1_busy, rf_qry2_busy;
  rob_tag_t rf_qry1_dep, rf_qry2_dep;
  word_t    rf_qry1_value, rf_qry2_value;

  modport master (
    output rob_clear, is_update_val, update_val_id, update_val_dep, update_val,
           is_update_dep, update_dep_id, update_dep, rf_qry1_id, rf_qry2_id,
    input  rf_qry1_busy, rf_qry2_busy, rf_qry1_dep, rf_qry2_dep,
           rf_qry1_value, rf_qry2_value
  );

  modport slave (
    input  rob_clear, is_update_val, update_val_id, update_val_dep, update_val,
           is_update_dep, update_dep_id, update_dep, rf_qry1_id, rf_qry2_id,
    output rf_qry1_busy, rf_qry2_busy, rf_qry1_dep, rf_qry2_dep,
           rf_qry1_value, rf_qry2_value
  );
endinterface

// File: rtl/reg_file_qry.sv
// One operand lookup: register state slice with a same-cycle commit bypass.
module reg_file_qry
  import reg_file_pkg::*;
(
  input  reg_idx_t qry_id,
  input  logic     st_busy,
  input  rob_tag_t st_dep,
  input  word_t    st_val,
  input  logic     cmt_vld,
  input  reg_idx_t cmt_id,
  input  rob_tag_t cmt_dep,
  input  word_t    cmt_val,
  output qry_rsp_t rsp
);
  always_comb begin
    rsp = '{busy: st_busy, dep: st_dep, value: st_val};
    if (qry_id == '0) begin
      rsp = '0;
    end else if (st_busy && cmt_vld && cmt_id == qry_id && cmt_dep == st_dep) begin
      // the producer is committing right now; hand its value straight through
      rsp.busy  = 1'b0;
      rsp.value = cmt_val;
    end
  end
endmodule

// File: rtl/reg_file.sv
// Architectural register file: 32 values with busy flag and ROB rename tag each.
module reg_file
  import reg_file_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  reg_file_if.slave  bus
);
  logic  [REG_NUM-1:0]              busy_q, busy_d;
  rob_tag_t [REG_NUM-1:0]           dep_q, dep_d;
  word_t [REG_NUM-1:0]              val_q, val_d;

  always_comb begin
    busy_d = busy_q;
    dep_d  = dep_q;
    val_d  = val_q;
    if (rdy_in) begin
      if (bus.rob_clear) begin
        busy_d = '0;
      end else begin
        if (bus.is_update_val && bus.update_val_id != '0) begin
          val_d[bus.update_val_id] = bus.update_val;
          // a stale tag writes the value but must not release a newer rename
          if (busy_q[bus.update_val_id] && dep_q[bus.update_val_id] == bus.update_val_dep)
            busy_d[bus.update_val_id] = 1'b0;
        end
        if (bus.is_update_dep && bus.update_dep_id != '0) begin
          busy_d[bus.update_dep_id] = 1'b1;
          dep_d[bus.update_dep_id]  = bus.update_dep;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      dep_q  <= '0;
      val_q  <= '0;
    end else begin
      busy_q <= busy_d;
      dep_q  <= dep_d;
      val_q  <= val_d;
    end
  end

  qry_rsp_t rsp1, rsp2;

  reg_file_qry u_qry1 (
    .qry_id (bus.rf_qry1_id),
    .st_busy(busy_q[bus.rf_qry1_id]),
    .st_dep (dep_q[bus.rf_qry1_id]),
    .st_val (val_q[bus.rf_qry1_id]),
    .cmt_vld(bus.is_update_val),
    .cmt_id (bus.update_val_id),
    .cmt_dep(bus.update_val_dep),
    .cmt_val(bus.update_val),
    .rsp    (rsp1)
  );

  reg_file_qry u_qry2 (
    .qry_id (bus.rf_qry2_id),
    .st_busy(busy_q[bus.rf_qry2_id]),
    .st_dep (dep_q[bus.rf_qry2_id]),
    .st_val (val_q[bus.rf_qry2_id]),
    .cmt_vld(bus.is_update_val),
    .cmt_id (bus.update_val_id),
    .cmt_dep(bus.update_val_dep),
    .cmt_val(bus.update_val),
    .rsp    (rsp2)
  );

  assign bus.rf_qry1_busy  = rsp1.busy;
  assign bus.rf_qry1_dep   = rsp1.dep;
  assign bus.rf_qry1_value = rsp1.value;
  assign bus.rf_qry2_busy  = rsp2.busy;
  assign bus.rf_qry2_dep   = rsp2.dep;
  assign bus.rf_qry2_value = rsp2.value;
endmodule

// File: tb/tb_reg_file.sv
// Directed vector bench for reg_file: each row drives one cycle and checks both query ports.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in;
  reg_file_if rf();

  reg_file dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(rf.slave));

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic     rdy, clr;
    logic     uv;  reg_idx_t uv_id; rob_tag_t uv_dep; word_t uval;
    logic     ud;  reg_idx_t ud_id; rob_tag_t ud_dep;
    reg_idx_t q1;  logic e1b; rob_tag_t e1d; word_t e1v;
    reg_idx_t q2;  logic e2b; rob_tag_t e2d; word_t e2v;
  } vec_t;

  vec_t vec[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic rdy, logic clr,
                              logic uv, int uv_id, int uv_dep, word_t uval,
                              logic ud, int ud_id, int ud_dep,
                              int q1, logic e1b, int e1d, word_t e1v,
                              int q2, logic e2b, int e2d, word_t e2v);
    vec_t v;
    v.rdy = rdy; v.clr = clr;
    v.uv = uv; v.uv_id = reg_idx_t'(uv_id); v.uv_dep = rob_tag_t'(uv_dep); v.uval = uval;
    v.ud = ud; v.ud_id = reg_idx_t'(ud_id); v.ud_dep = rob_tag_t'(ud_dep);
    v.q1 = reg_idx_t'(q1); v.e1b = e1b; v.e1d = rob_tag_t'(e1d); v.e1v = e1v;
    v.q2 = reg_idx_t'(q2); v.e2b = e2b; v.e2d = rob_tag_t'(e2d); v.e2v = e2v;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // dep is meaningful only while busy (or for x0), value only while not busy
  task automatic chk_port(string tag, reg_idx_t id, logic b, rob_tag_t d, word_t v,
                          logic eb, rob_tag_t ed, word_t ev);
    chk($sformatf("%s x%0d busy", tag, id), 32'(b), 32'(eb));
    if (eb || id == '0) chk($sformatf("%s x%0d dep", tag, id), 32'(d), 32'(ed));
    if (!eb)            chk($sformatf("%s x%0d value", tag, id), v, ev);
  endtask

  task automatic drive(vec_t v);
    rdy_in            = v.rdy;
    rf.rob_clear      = v.clr;
    rf.is_update_val  = v.uv;
    rf.update_val_id  = v.uv_id;
    rf.update_val_dep = v.uv_dep;
    rf.update_val     = v.uval;
    rf.is_update_dep  = v.ud;
    rf.update_dep_id  = v.ud_id;
    rf.update_dep     = v.ud_dep;
    rf.rf_qry1_id     = v.q1;
    rf.rf_qry2_id     = v.q2;
  endtask

  initial begin
    //             rdy clr  uv id dep val          ud id dep  q1 b d val           q2 b d val
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   5, 0,0,0,            0, 0,0,0));           // reset state
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            1, 5, 3,   5, 0,0,0,            0, 0,0,0));           // rename invisible same cycle
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   5, 1,3,0,            0, 0,0,0));
    vec.push_back(mk(1, 0,  1, 5, 3, 32'hDEADBEEF, 0, 0, 0,   5, 0,3,32'hDEADBEEF, 5, 0,3,32'hDEADBEEF)); // bypass
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   5, 0,3,32'hDEADBEEF, 0, 0,0,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            1, 7, 2,   7, 0,0,0,            0, 0,0,0));           // stale commit
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            1, 7, 4,   7, 1,2,0,            0, 0,0,0));
    vec.push_back(mk(1, 0,  1, 7, 2, 32'h11,       0, 0, 0,   7, 1,4,0,            0, 0,0,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   7, 1,4,0,            0, 0,0,0));
    vec.push_back(mk(1, 1,  0, 0, 0, 0,            0, 0, 0,   7, 1,4,0,            0, 0,0,0));           // clear exposes stored val
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   7, 0,4,32'h11,       0, 0,0,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            1, 9, 1,   9, 0,0,0,            0, 0,0,0));           // same-cycle commit+rename
    vec.push_back(mk(1, 0,  1, 9, 1, 32'h55,       1, 9, 6,   9, 0,1,32'h55,       9, 0,1,32'h55));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   9, 1,6,0,            0, 0,0,0));
    vec.push_back(mk(1, 1,  0, 0, 0, 0,            0, 0, 0,   9, 1,6,0,            0, 0,0,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   9, 0,6,32'h55,       0, 0,0,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            1, 1, 2,   1, 0,0,0,            0, 0,0,0));           // clear vs rename
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            1, 2, 5,   1, 1,2,0,            0, 0,0,0));
    vec.push_back(mk(1, 1,  0, 0, 0, 0,            1, 3, 7,   1, 1,2,0,            2, 1,5,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   1, 0,2,0,            2, 0,5,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   3, 0,0,0,            3, 0,0,0));
    vec.push_back(mk(1, 0,  1, 0, 0, 32'h99,       1, 0, 1,   0, 0,0,0,            0, 0,0,0));           // x0 writes dropped
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   0, 0,0,0,            0, 0,0,0));
    vec.push_back(mk(0, 0,  0, 0, 0, 0,            1, 4, 2,   4, 0,0,0,            0, 0,0,0));           // stall
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   4, 0,0,0,            0, 0,0,0));
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            1, 6, 3,   6, 0,0,0,            0, 0,0,0));
    vec.push_back(mk(0, 1,  0, 0, 0, 0,            0, 0, 0,   6, 1,3,0,            0, 0,0,0));           // stalled clear
    vec.push_back(mk(0, 0,  1, 6, 3, 32'h77,       0, 0, 0,   6, 0,3,32'h77,       0, 0,0,0));           // bypass while stalled
    vec.push_back(mk(1, 0,  0, 0, 0, 0,            0, 0, 0,   6, 1,3,0,            0, 0,0,0));

    drive(mk(1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      if (i != 0) @(negedge clk_in);
      drive(vec[i]);
      #1;
      chk_port($sformatf("v%0d q1", i), vec[i].q1, rf.rf_qry1_busy, rf.rf_qry1_dep,
               rf.rf_qry1_value, vec[i].e1b, vec[i].e1d, vec[i].e1v);
      chk_port($sformatf("v%0d q2", i), vec[i].q2, rf.rf_qry2_busy, rf.rf_qry2_dep,
               rf.rf_qry2_value, vec[i].e2b, vec[i].e2d, vec[i].e2v);
    end

    // reset with rdy_in low still wipes state, including a pending rename
    @(negedge clk_in);
    drive(mk(1,0, 0,0,0,0, 1,10,5, 10,0,0,0, 0,0,0,0));
    @(negedge clk_in);
    drive(mk(0,0, 0,0,0,0, 0,0,0, 10,1,5,0, 0,0,0,0));
    #1;
    chk_port("pre-rst q1", 5'd10, rf.rf_qry1_busy, rf.rf_qry1_dep, rf.rf_qry1_value, 1'b1, 4'd5, 32'h0);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(mk(1,0, 0,0,0,0, 0,0,0, 10,0,0,0, 5,0,0,0));
    #1;
    chk("rst x10 busy", 32'(rf.rf_qry1_busy), 32'h0);
    chk("rst x10 dep",  32'(rf.rf_qry1_dep),  32'h0);
    chk("rst x5 value", rf.rf_qry2_value,     32'h0);
    chk("rst x5 dep",   32'(rf.rf_qry2_dep),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the out-of-order core. Holds 32 × 32-bit values plus a per-register busy flag and ROB dependency tag. It consumes the ROB's commit/rename update interface (`is_update_val`/`is_update_dep`) and the ROB clear, and answers two combinational operand queries from the Decoder. On a query it returns either a ready value or the ROB id the operand waits on.

## Interface
- `REG_NUM`, 32: number of architectural registers; index width is fixed at 5.
- `ROB_SIZE_BIT`, from `Config.v`: ROB tag width.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  when low, state holds and all updates are ignored; queries stay live.
- `rob_clear`  in  1  misprediction flush from ROB.
- `is_update_val`  in  1  commit write strobe.
- `update_val_id`  in  5  committed rd.
- `update_val_dep`  in  ROB_SIZE_BIT  ROB id of the committing entry.
- `update_val`  in  32  committed value.
- `is_update_dep`  in  1  rename strobe for the issuing instruction.
- `update_dep_id`  in  5  renamed rd.
- `update_dep`  in  ROB_SIZE_BIT  new ROB tag.
- `rf_qry1_id`, `rf_qry2_id`  in  5  source register indices.
- `rf_qry1_busy`, `rf_qry2_busy`  out  1  operand not yet available.
- `rf_qry1_dep`, `rf_qry2_dep`  out  ROB_SIZE_BIT  producing ROB id; valid when busy.
- `rf_qry1_value`, `rf_qry2_value`  out  32  operand value; valid when not busy.

## Operation
- State: `val[32]`, `busy[32]`, `dep[32]`.
- x0 is hardwired:
  - queries of x0 return value 0, busy 0, dep 0;
  - commit and rename targeting x0 are ignored.
- Clear has top priority. When `rob_clear` is high with `rdy_in` high:
  - every `busy` bit goes to 0;
  - `dep` and `val` are kept;
  - both commit and rename in the same cycle are ignored.
- Commit (`is_update_val`, no clear): `val[id] <= update_val` unconditionally. `busy[id]` is cleared only when `busy[id] && dep[id]==update_val_dep`. A stale tag updates the value but leaves the newer rename pending.
- Rename (`is_update_dep`, no clear): `busy[id] <= 1`, `dep[id] <= update_dep`.
- Commit and rename on the same register in the same cycle: rename wins for `busy` and `dep`, and the commit value is still written.
- Query forwarding (combinational, per port, non-x0):
  - if `busy[q]` and `is_update_val && update_val_id==q && update_val_dep==dep[q]`, output busy 0 and value `update_val`;
  - otherwise output `busy[q]`, `dep[q]`, `val[q]`.
- Queries never see a same-cycle rename. This way an instruction whose rs equals its own rd reads the prior mapping.
- Forwarding applies regardless of `rob_clear` and `rdy_in`. The Decoder does not issue during clear.

## Timing
- Query latency: 0 cycles (pure combinational from state plus the commit bypass).
- Commit, rename and clear take effect at the next `clk_in` rising edge; the first query to reflect them is in the following cycle.
- Reset (synchronous, when `rst_in` is high at the edge): all `val`, `busy`, `dep` go to 0. All query outputs are therefore 0, busy 0, until the first update. Reset overrides `rdy_in`.
- `rdy_in` low: no state change, including clear.
- Tag wrap-around: tags are compared for equality only. Width is ROB_SIZE_BIT, with no extra bits.

## Structure
- `ROB_SIZE_BIT` and `ROB_SIZE` come from the shared `Config.v`; no new constants are needed there.
- The two query ports are identical. Implement them as one small combinational sub-module, `reg_file_qry`, instantiated twice. Inputs: state slice plus the commit bypass. Outputs: busy, dep, value.
- The storage and update priority logic live in `reg_file` itself.

## Test plan
- Reset, then query x5 -> busy 0, value 0, dep 0.
- Rename x5 → tag 3 and query x5 next cycle -> busy 1, dep 3. Commit x5, tag 3, value 0xDEADBEEF -> same cycle query busy 0, value 0xDEADBEEF; next cycle same from state.
- Stale commit:
  - stimulus: rename x7 → 2, rename x7 → 4, commit x7 tag 2 value 0x11;
  - response: `val` is 0x11 but busy 1, dep 4; query returns busy 1, dep 4.
- Same-cycle rename and commit on x9 (busy, tag 1), commit tag 1 value 0x55, rename tag 6 -> next cycle busy 1, dep 6, `val`=0x55; same-cycle query busy 0, value 0x55.
- Clear: busy x1 (tag 2), x2 (tag 5); `rob_clear` with a concurrent rename x3 → 7 -> next cycle all busy 0, and x3 is not busy.
- x0 and stall:
  - rename x0 → 1, then query x0 -> busy 0, value 0;
  - with `rdy_in`=0, rename x4 → 2 -> x4 stays not busy.
